fetch_redirect_controller: RTL and testbench

Sequencing controller for the fetch-stage program counter. It collects stall requests and control-flow redirects from the pipeline (ID-stage jumps, EX-stage taken branches, exceptions) and arbitrates between them by fixed priority. It then drives the program counter's freeze and jump inputs with registered, single-source commands, and generates the matching IF/ID flush pulses. It sits between the hazard/branch/exception logic and the program counter.

---
 rtl/fetch_redirect_controller.sv | 147 ++++++++++++++
 tb/tb_fetch_redirect_controller.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_redirect_controller.sv
// Fetch-stage PC sequencer: arbitrates stalls and redirects into registered,
// one-hot freeze/jump commands for the program counter plus IF/ID flush pulses.
module fetch_redirect_controller #(
  parameter int          FREEZE_W   = 4,
  parameter logic [31:0] EXC_VECTOR = 32'h00004180
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                stall_req,
  input  logic [FREEZE_W-1:0] stall_cycles,
  input  logic                id_jump,
  input  logic [31:0]         id_jump_target,
  input  logic                ex_branch_taken,
  input  logic [31:0]         ex_branch_target,
  input  logic                exc_req,
  output logic                jump_enabled,
  output logic [31:0]         jump_target,
  output logic                freeze,
  output logic                flush_if,
  output logic                flush_id,
  output logic                pending
);

  typedef enum logic {RUN, FREEZE} state_t;

  // Redirect priority level: 3 = exception, 2 = EX branch, 1 = ID jump, 0 = none.
  typedef logic [1:0] level_t;

  state_t              state_q, state_d;
  logic [FREEZE_W-1:0] cnt_q, cnt_d;
  level_t              pend_lvl_q, pend_lvl_d;
  logic [31:0]         pend_tgt_q, pend_tgt_d;
  logic                jump_en_q, jump_en_d;
  logic [31:0]         jump_tgt_q, jump_tgt_d;
  logic                freeze_q, freeze_d;
  logic                flush_if_q, flush_if_d;
  logic                flush_id_q, flush_id_d;

  level_t      req_lvl;
  logic [31:0] req_tgt;
  level_t      issue_lvl;
  logic [31:0] issue_tgt;

  always_comb begin
    req_lvl = 2'd0;
    req_tgt = 32'h0;
    if (exc_req) begin
      req_lvl = 2'd3;
      req_tgt = EXC_VECTOR;
    end else if (ex_branch_taken) begin
      req_lvl = 2'd2;
      req_tgt = ex_branch_target;
    end else if (id_jump) begin
      req_lvl = 2'd1;
      req_tgt = id_jump_target;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_lvl_d = pend_lvl_q;
    pend_tgt_d = pend_tgt_q;
    issue_lvl  = 2'd0;
    issue_tgt  = 32'h0;
    freeze_d   = 1'b0;

    case (state_q)
      RUN: begin
        if (req_lvl != 2'd0) begin
          issue_lvl = req_lvl;
          issue_tgt = req_tgt;
        end else if (stall_req && (stall_cycles != '0)) begin
          cnt_d    = stall_cycles;
          freeze_d = 1'b1;
          state_d  = FREEZE;
        end
      end
      FREEZE: begin
        if (exc_req) begin
          issue_lvl  = 2'd3;
          issue_tgt  = EXC_VECTOR;
          pend_lvl_d = 2'd0;
          cnt_d      = '0;
          state_d    = RUN;
        end else if (cnt_q == FREEZE_W'(1)) begin
          // Ties go to the older buffered entry, matching the capture rule.
          if (req_lvl > pend_lvl_q) begin
            issue_lvl = req_lvl;
            issue_tgt = req_tgt;
          end else begin
            issue_lvl = pend_lvl_q;
            issue_tgt = pend_tgt_q;
          end
          pend_lvl_d = 2'd0;
          cnt_d      = '0;
          state_d    = RUN;
        end else begin
          cnt_d    = cnt_q - FREEZE_W'(1);
          freeze_d = 1'b1;
          if (req_lvl > pend_lvl_q) begin
            pend_lvl_d = req_lvl;
            pend_tgt_d = req_tgt;
          end
        end
      end
      default: state_d = RUN;
    endcase

    jump_en_d  = (issue_lvl != 2'd0);
    jump_tgt_d = jump_en_d ? {issue_tgt[31:2], 2'b00} : 32'h0;
    flush_if_d = jump_en_d;
    flush_id_d = (issue_lvl >= 2'd2);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      pend_lvl_q <= 2'd0;
      pend_tgt_q <= 32'h0;
      jump_en_q  <= 1'b0;
      jump_tgt_q <= 32'h0;
      freeze_q   <= 1'b0;
      flush_if_q <= 1'b0;
      flush_id_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_lvl_q <= pend_lvl_d;
      pend_tgt_q <= pend_tgt_d;
      jump_en_q  <= jump_en_d;
      jump_tgt_q <= jump_tgt_d;
      freeze_q   <= freeze_d;
      flush_if_q <= flush_if_d;
      flush_id_q <= flush_id_d;
    end
  end

  assign jump_enabled = jump_en_q;
  assign jump_target  = jump_tgt_q;
  assign freeze       = freeze_q;
  assign flush_if     = flush_if_q;
  assign flush_id     = flush_id_q;
  assign pending      = (pend_lvl_q != 2'd0);

endmodule

// File: tb/tb_fetch_redirect_controller.sv
// Self-checking bench for fetch_redirect_controller: directed vector table
// followed by random traffic compared against a cycle-level reference model.
module tb_fetch_redirect_controller;

  localparam logic [31:0] EXC = 32'h00004180;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall_req;
  logic [3:0]  stall_cycles;
  logic        id_jump;
  logic [31:0] id_jump_target;
  logic        ex_branch_taken;
  logic [31:0] ex_branch_target;
  logic        exc_req;
  logic        jump_enabled;
  logic [31:0] jump_target;
  logic        freeze;
  logic        flush_if;
  logic        flush_id;
  logic        pending;

  always #5 clock = ~clock;

  fetch_redirect_controller #(.FREEZE_W(4), .EXC_VECTOR(EXC)) dut (
    .clock            (clock),
    .reset            (reset),
    .stall_req        (stall_req),
    .stall_cycles     (stall_cycles),
    .id_jump          (id_jump),
    .id_jump_target   (id_jump_target),
    .ex_branch_taken  (ex_branch_taken),
    .ex_branch_target (ex_branch_target),
    .exc_req          (exc_req),
    .jump_enabled     (jump_enabled),
    .jump_target      (jump_target),
    .freeze           (freeze),
    .flush_if         (flush_if),
    .flush_id         (flush_id),
    .pending          (pending)
  );

  typedef struct {
    logic        rst;
    logic        stall;
    logic [3:0]  cyc;
    logic        id;
    logic [31:0] idt;
    logic        ex;
    logic [31:0] ext;
    logic        exc;
    logic [36:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  // Expected-output packing: {jump_enabled, jump_target, freeze, flush_if, flush_id, pending}.
  function automatic logic [36:0] outs(input logic je, input logic [31:0] tgt, input logic frz,
                                       input logic fif, input logic fid, input logic pnd);
    return {je, tgt, frz, fif, fid, pnd};
  endfunction

  function automatic vec_t mk(input logic rst, input logic stall, input logic [3:0] cyc,
                              input logic id, input logic [31:0] idt, input logic ex,
                              input logic [31:0] ext, input logic exc, input logic [36:0] exp);
    vec_t v;
    v.rst = rst; v.stall = stall; v.cyc = cyc; v.id = id; v.idt = idt;
    v.ex = ex; v.ext = ext; v.exc = exc; v.exp = exp;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    reset            = v.rst;
    stall_req        = v.stall;
    stall_cycles     = v.cyc;
    id_jump          = v.id;
    id_jump_target   = v.idt;
    ex_branch_taken  = v.ex;
    ex_branch_target = v.ext;
    exc_req          = v.exc;
  endtask

  task automatic checkOutput(input string name, input logic [36:0] exp);
    logic [36:0] act;
    act = {jump_enabled, jump_target, freeze, flush_if, flush_id, pending};
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got je=%b tgt=%h frz=%b fif=%b fid=%b pend=%b, want je=%b tgt=%h frz=%b fif=%b fid=%b pend=%b",
               name, act[36], act[35:4], act[3], act[2], act[1], act[0],
               exp[36], exp[35:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Reference model: freeze cycles still to emit, and the best redirect seen while frozen.
  int          m_left;
  int          m_buf_lvl;
  logic [31:0] m_buf_tgt;
  logic [36:0] m_exp;

  task automatic modelStep(input vec_t v);
    int          rl;
    logic [31:0] rt;
    int          il;
    logic [31:0] it;
    logic        frz;
    il = 0; it = 32'h0; frz = 1'b0;
    rl = v.exc ? 3 : (v.ex ? 2 : (v.id ? 1 : 0));
    rt = v.exc ? EXC : (v.ex ? v.ext : v.idt);
    if (v.rst) begin
      m_left = 0;
      m_buf_lvl = 0;
    end else if (m_left > 0) begin
      if (v.exc) begin
        il = 3; it = EXC; m_left = 0; m_buf_lvl = 0;
      end else if (m_left == 1) begin
        m_left = 0;
        if (rl > m_buf_lvl) begin il = rl; it = rt; end
        else begin il = m_buf_lvl; it = m_buf_tgt; end
        m_buf_lvl = 0;
      end else begin
        m_left--;
        frz = 1'b1;
        if (rl > m_buf_lvl) begin m_buf_lvl = rl; m_buf_tgt = rt; end
      end
    end else if (rl > 0) begin
      il = rl; it = rt;
    end else if (v.stall && v.cyc != 0) begin
      m_left = int'(v.cyc);
      frz = 1'b1;
    end
    m_exp = outs(il != 0, (il != 0) ? {it[31:2], 2'b00} : 32'h0, frz, il != 0, il >= 2,
                 m_buf_lvl != 0);
  endtask

  initial begin
    vec_t v;
    logic [36:0] z;
    z = outs(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Basic redirect, priority and alignment.
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, z));
    vecs.push_back(mk(0, 0, 0, 1, 32'h3020, 0, 0, 0, outs(1, 32'h3020, 0, 1, 0, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, z));
    vecs.push_back(mk(0, 0, 0, 1, 32'h3020, 1, 32'h3100, 1, outs(1, EXC, 0, 1, 1, 0)));
    vecs.push_back(mk(0, 0, 0, 1, 32'h3020, 1, 32'h3103, 0, outs(1, 32'h3100, 0, 1, 1, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, z));
    // Stall length 3, then a zero-length stall.
    vecs.push_back(mk(0, 1, 3, 0, 0, 0, 0, 0, outs(0, 0, 1, 0, 0, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, outs(0, 0, 1, 0, 0, 0)));
    vecs.push_back(mk(0, 1, 5, 0, 0, 0, 0, 0, outs(0, 0, 1, 0, 0, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, z));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, z));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, z));
    // Buffered redirect: ID jump then higher-priority EX branch inside a 3-cycle freeze.
    vecs.push_back(mk(0, 1, 3, 0, 0, 0, 0, 0, outs(0, 0, 1, 0, 0, 0)));
    vecs.push_back(mk(0, 0, 0, 1, 32'h3020, 0, 0, 0, outs(0, 0, 1, 0, 0, 1)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h3200, 0, outs(0, 0, 1, 0, 0, 1)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, outs(1, 32'h3200, 0, 1, 1, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, z));
    // Exception aborts freeze cycle 2 of 4.
    vecs.push_back(mk(0, 1, 4, 0, 0, 0, 0, 0, outs(0, 0, 1, 0, 0, 0)));
    vecs.push_back(mk(0, 0, 0, 1, 32'h3040, 0, 0, 0, outs(0, 0, 1, 0, 0, 1)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, outs(1, EXC, 0, 1, 1, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, z));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, z));
    // Reset mid-freeze with a redirect pending.
    vecs.push_back(mk(0, 1, 3, 0, 0, 0, 0, 0, outs(0, 0, 1, 0, 0, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h3300, 0, outs(0, 0, 1, 0, 0, 1)));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, z));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, z));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, z));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, z));
    // New request in the last freeze cycle beats the buffered lower-priority entry.
    vecs.push_back(mk(0, 1, 2, 0, 0, 0, 0, 0, outs(0, 0, 1, 0, 0, 0)));
    vecs.push_back(mk(0, 0, 0, 1, 32'h3050, 0, 0, 0, outs(0, 0, 1, 0, 0, 1)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 32'h3060, 0, outs(1, 32'h3060, 0, 1, 1, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, z));
    // Stall arriving with a redirect in RUN is discarded.
    vecs.push_back(mk(0, 1, 3, 1, 32'h3070, 0, 0, 0, outs(1, 32'h3070, 0, 1, 0, 0)));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, z));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(posedge clock);
      #1;
      checkOutput($sformatf("vec%0d", i), vecs[i].exp);
    end

    m_left = 0;
    m_buf_lvl = 0;
    m_buf_tgt = 32'h0;
    for (int c = 0; c < 600; c++) begin
      v.rst   = (c == 0) || ($urandom_range(0, 59) == 0);
      v.stall = ($urandom_range(0, 3) == 0);
      v.cyc   = 4'($urandom_range(0, 5));
      v.id    = ($urandom_range(0, 5) == 0);
      v.idt   = $urandom;
      v.ex    = ($urandom_range(0, 7) == 0);
      v.ext   = $urandom;
      v.exc   = ($urandom_range(0, 19) == 0);
      v.exp   = '0;
      applyStimulus(v);
      @(posedge clock);
      #1;
      modelStep(v);
      checkOutput($sformatf("rand%0d", c), m_exp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
